// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU phase sequencer: widths, opcode and phase
// encodings, and the ALU-opcode classifier.
package cpu_pkg;

    localparam int OPC_W   = 3;
    localparam int PHASE_W = 3;

    typedef enum logic [OPC_W-1:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    typedef enum logic [PHASE_W-1:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    // Opcodes that read an operand from memory into the accumulator path.
    function automatic logic is_aluop(input logic [OPC_W-1:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Wrapping 3-bit instruction-phase counter; holds its value while freeze is high.
module phase_counter
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   freeze,
    output phase_t phase
);

    phase_t phase_q;
    phase_t phase_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_INST_ADDR;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (!freeze) begin
            phase_d = phase_t'(phase_q + PHASE_W'(1));
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/cpu_controller.sv
// 8-phase instruction-cycle controller: decodes phase, opcode and zero flag
// into datapath strobes, with a sticky halt that freezes the sequence.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               zero,
    output logic               sel,
    output logic               rd,
    output logic               ld_ir,
    output logic               inc_pc,
    output logic               ld_pc,
    output logic               ld_ac,
    output logic               wr,
    output logic               data_e,
    output logic               halt,
    output logic [PHASE_W-1:0] phase
);

    phase_t ph;
    logic   halted_q;
    logic   halted_d;
    logic   aluop;

    // The halted flag sets on the same edge that moves phase 4 -> 5, then
    // freezes the counter there until reset.
    phase_counter u_phase_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .freeze (halted_q),
        .phase  (ph)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    always_comb begin
        halted_d = halted_q;
        if (ph == PH_OP_ADDR && opcode == OP_HLT) begin
            halted_d = 1'b1;
        end
    end

    assign aluop = is_aluop(opcode);
    assign phase = ph;

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted_q) begin
            sel  = 1'b1;
            halt = 1'b1;
        end else begin
            // opcode and zero are only looked at in phases 4-7.
            case (ph)
                PH_INST_ADDR: begin
                end
                PH_INST_FETCH: begin
                    rd = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    sel    = 1'b1;
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                PH_OP_FETCH: begin
                    sel = 1'b1;
                    rd  = aluop;
                end
                PH_ALU_OP: begin
                    sel    = 1'b1;
                    rd     = aluop;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                PH_STORE: begin
                    sel    = 1'b1;
                    rd     = aluop;
                    ld_ac  = aluop;
                    inc_pc = (opcode == OP_JMP);
                    ld_pc  = (opcode == OP_JMP);
                    wr     = (opcode == OP_STO);
                    data_e = (opcode == OP_STO);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
